// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU memory stage: word-addressed backing store
// with a programmable number of stall cycles per access and an out-of-range flag.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        ErrorM
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT   = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_M1  = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          complete;

  assign req    = MemReadM | MemWriteM;
  // Unsigned subtraction: addresses below the base wrap high and fail the range test.
  assign offset   = AddrM - BASE_ADDR;
  assign in_range = ({1'b0, offset} < LIMIT);
  assign idx      = offset[AW+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    StallMem = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            complete = 1'b1;
          end else begin
            StallMem = 1'b1;
            cnt_d    = LAT_M1;
            state_d  = (LATENCY == 1) ? DONE : WAIT;
          end
        end
      end
      WAIT: begin
        StallMem = 1'b1;
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        complete = req;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    // Reset silences the in-flight access so nothing commits or reports.
    if (reset) begin
      StallMem = 1'b0;
      complete = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (complete && MemWriteM && in_range) begin
      mem[idx] <= WriteDataM;
    end
  end

  assign ReadDataM = (complete && MemReadM && in_range) ? mem[idx] : 32'h0;
  assign ErrorM    = complete && !in_range;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 0, 3, 2) checked every cycle
// against a request-age model, plus directed literal expectations.
module tb_dmem_responder;

  localparam int N     = 3;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_s   [N];
  logic        wr_s   [N];
  logic [31:0] addr_s [N];
  logic [31:0] wd_s   [N];
  logic [31:0] rdat_s [N];
  logic        stall_s[N];
  logic        err_s  [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .LATENCY    ((gi == 0) ? 0 : ((gi == 1) ? 3 : 2)),
        .BASE_ADDR  (32'h0000_0000)
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .MemReadM  (rd_s[gi]),
        .MemWriteM (wr_s[gi]),
        .AddrM     (addr_s[gi]),
        .WriteDataM(wd_s[gi]),
        .ReadDataM (rdat_s[gi]),
        .StallMem  (stall_s[gi]),
        .ErrorM    (err_s[gi])
      );
    end
  endgenerate

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
    end
  endtask

  // Model: an access completes once its request has been held LATENCY cycles.
  int          age [N];
  logic [31:0] mm  [N][DEPTH];
  bit          mv  [N][DEPTH];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic        req, e_stall, e_err, known, inr;
      logic [31:0] e_rd, off;
      int          idx;
      req     = rd_s[i] | wr_s[i];
      off     = addr_s[i];
      inr     = (off < 32'd256);
      idx     = int'(off[7:2]);
      e_stall = 1'b0;
      e_err   = 1'b0;
      e_rd    = 32'h0;
      known   = 1'b1;
      if (reset) begin
        age[i] = 0;
      end else if (!req) begin
        // Dropping the request mid-wait still shows the stall for that cycle.
        e_stall = (age[i] >= 1) && (age[i] < lat_of(i));
        age[i]  = 0;
      end else if (age[i] < lat_of(i)) begin
        e_stall = 1'b1;
        age[i]  = age[i] + 1;
      end else begin
        e_err = !inr;
        if (rd_s[i] && inr) begin
          known = mv[i][idx];
          e_rd  = mm[i][idx];
        end
        if (wr_s[i] && inr) begin
          mm[i][idx] = wd_s[i];
          mv[i][idx] = 1'b1;
        end
        age[i] = 0;
      end
      chk("stall", i, {31'b0, stall_s[i]}, {31'b0, e_stall});
      chk("error", i, {31'b0, err_s[i]}, {31'b0, e_err});
      if (known) chk("rdata", i, rdat_s[i], e_rd);
    end
  end

  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdata, output bit err,
                        output int stalls);
    rd_s[i]   = r;
    wr_s[i]   = w;
    addr_s[i] = a;
    wd_s[i]   = d;
    stalls    = 0;
    rdata     = 32'h0;
    err       = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall_s[i]) begin
        stalls++;
        @(posedge clk);
        #1;
      end else begin
        rdata = rdat_s[i];
        err   = err_s[i];
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout dut%0d addr %h: got no completion, required one within 40 cycles", i, a);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) begin
      rd_s[i] = 1'b0;
      wr_s[i] = 1'b0;
    end
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] rd;
  bit          e;
  int          s;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      rd_s[i]   = 1'b0;
      wr_s[i]   = 1'b0;
      addr_s[i] = 32'h0;
      wd_s[i]   = 32'h0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 1, {31'b0, stall_s[1]}, 32'h0);
    chk("reset_rdata", 1, rdat_s[1], 32'h0);
    chk("reset_error", 1, {31'b0, err_s[1]}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Latency 0: single-cycle accesses, never stalled
    access(0, 0, 1, 32'h10, 32'hDEADBEEF, rd, e, s);
    chk("l0_wr_stalls", 0, 32'(s), 32'd0);
    access(0, 1, 0, 32'h10, 32'h0, rd, e, s);
    chk("l0_rd_stalls", 0, 32'(s), 32'd0);
    chk("l0_rd_data", 0, rd, 32'hDEADBEEF);
    access(0, 0, 1, 32'h0, 32'h11111111, rd, e, s);
    access(0, 0, 1, 32'hFC, 32'h22222222, rd, e, s);
    access(0, 0, 1, 32'h100, 32'hBAD0BAD0, rd, e, s);
    chk("l0_oor_hi_wr_err", 0, {31'b0, e}, 32'd1);
    access(0, 1, 0, 32'h100, 32'h0, rd, e, s);
    chk("l0_oor_hi_rd_err", 0, {31'b0, e}, 32'd1);
    chk("l0_oor_hi_rd_data", 0, rd, 32'h0);
    access(0, 0, 1, 32'hFFFFFFFC, 32'hBAD1BAD1, rd, e, s);
    chk("l0_oor_lo_wr_err", 0, {31'b0, e}, 32'd1);
    access(0, 1, 0, 32'hFFFFFFFC, 32'h0, rd, e, s);
    chk("l0_oor_lo_rd_err", 0, {31'b0, e}, 32'd1);
    chk("l0_oor_lo_rd_data", 0, rd, 32'h0);
    access(0, 1, 0, 32'h0, 32'h0, rd, e, s);
    chk("l0_word0_kept", 0, rd, 32'h11111111);
    access(0, 1, 0, 32'hFC, 32'h0, rd, e, s);
    chk("l0_word63_kept", 0, rd, 32'h22222222);
    idle(2);

    // Latency 3: three stalls, then one completing cycle
    access(1, 0, 1, 32'h20, 32'hCAFEF00D, rd, e, s);
    chk("l3_wr_stalls", 1, 32'(s), 32'd3);
    idle(1);
    access(1, 1, 0, 32'h20, 32'h0, rd, e, s);
    chk("l3_rd_stalls", 1, 32'(s), 32'd3);
    chk("l3_rd_data", 1, rd, 32'hCAFEF00D);
    rd_s[1] = 1'b0;
    @(negedge clk);
    chk("l3_rd_after", 1, rdat_s[1], 32'h0);
    idle(1);

    // Reset while a write is waiting abandons it
    access(1, 0, 1, 32'h24, 32'h00000001, rd, e, s);
    rd_s[1]   = 1'b0;
    wr_s[1]   = 1'b1;
    addr_s[1] = 32'h24;
    wd_s[1]   = 32'h00000099;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    wr_s[1] = 1'b0;
    @(negedge clk);
    chk("l3_post_reset_stall", 1, {31'b0, stall_s[1]}, 32'h0);
    idle(1);
    access(1, 1, 0, 32'h24, 32'h0, rd, e, s);
    chk("l3_reset_no_write", 1, rd, 32'h00000001);
    idle(2);

    // Latency 2: aborted write, back-to-back, both strobes, out of range
    access(2, 0, 1, 32'h40, 32'hAAAA5555, rd, e, s);
    chk("l2_wr_stalls", 2, 32'(s), 32'd2);
    wr_s[2]   = 1'b1;
    addr_s[2] = 32'h40;
    wd_s[2]   = 32'h12345678;
    @(posedge clk);
    #1;
    wr_s[2] = 1'b0;
    idle(2);
    access(2, 1, 0, 32'h40, 32'h0, rd, e, s);
    chk("l2_abort_no_write", 2, rd, 32'hAAAA5555);
    access(2, 0, 1, 32'h8, 32'h5, rd, e, s);
    chk("l2_b2b_wr_stalls", 2, 32'(s), 32'd2);
    access(2, 1, 0, 32'h8, 32'h0, rd, e, s);
    chk("l2_b2b_rd_stalls", 2, 32'(s), 32'd2);
    chk("l2_b2b_rd_data", 2, rd, 32'h5);
    access(2, 1, 1, 32'h8, 32'h7, rd, e, s);
    chk("l2_rw_pre_write", 2, rd, 32'h5);
    access(2, 1, 0, 32'h8, 32'h0, rd, e, s);
    chk("l2_rw_committed", 2, rd, 32'h7);
    access(2, 1, 0, 32'h100, 32'h0, rd, e, s);
    chk("l2_oor_stalls", 2, 32'(s), 32'd2);
    chk("l2_oor_err", 2, {31'b0, e}, 32'd1);
    chk("l2_oor_data", 2, rd, 32'h0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
